// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol monitor: tracks IDLE/SETUP/ACCESS, flags protocol and
// register-map violations, and keeps transfer/error/wait-state statistics.
module apb_protocol_monitor #(
    parameter int                   ADDR_WIDTH   = 8,
    parameter int                   DATA_WIDTH   = 8,
    parameter int                   REG_COUNT    = 8,
    parameter logic [REG_COUNT-1:0] WR_ONLY_MASK = 8'b0101_0100,
    parameter logic [REG_COUNT-1:0] RD_ONLY_MASK = 8'b0010_1000,
    parameter int                   MAX_WAIT     = 16,
    parameter int                   CNT_WIDTH    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  clr_i,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [6:0]            err_status,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [7:0]            wait_max
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]              wait_q, wait_d, wait_inc;
    logic                    w6_fired_q, w6_fired_d;

    logic                    err_valid_q;
    logic [2:0]              err_code_q, err_code_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [6:0]              err_status_q;
    logic [CNT_WIDTH-1:0]    wr_cnt_q, rd_cnt_q, err_cnt_q;
    logic [7:0]              wait_max_q;

    logic                    setup_ph, access_ph, in_setup, acc_smp, done, setup_entry;
    logic [6:0]              err_hit;

    // Read data is part of the observed bus but carries no protocol rule here.
    logic                    unused_prdata;
    assign unused_prdata = ^PRDATA;

    function automatic logic addr_in_map(input logic [ADDR_WIDTH-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (a == ADDR_WIDTH'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic mask_bit(input logic [REG_COUNT-1:0] mask,
                                      input logic [ADDR_WIDTH-1:0] a);
        logic b;
        b = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (a == ADDR_WIDTH'(i)) b = mask[i];
        end
        return b;
    endfunction

    function automatic logic [2:0] lowest_code(input logic [6:0] hits);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (hits[i]) c = 3'(i + 1);
        end
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            w6_fired_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            w6_fired_q <= w6_fired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup_ph) state_d = S_SETUP;
            end
            S_SETUP, S_ACCESS: begin
                if (access_ph)     state_d = PREADY ? S_IDLE : S_ACCESS;
                else if (setup_ph) state_d = S_SETUP;
                else               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State_q==SETUP means the setup phase was just sampled, so this edge sees
    // the first access-phase sample as well as the post-setup map checks.
    always_comb begin
        setup_ph    = PSELx & ~PENABLE;
        access_ph   = PSELx & PENABLE;
        in_setup    = (state_q == S_SETUP);
        acc_smp     = (in_setup || state_q == S_ACCESS) && access_ph;
        done        = acc_smp & PREADY;
        setup_entry = (state_d == S_SETUP);
    end

    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        if (setup_entry) begin
            addr_d  = PADDR;
            write_d = PWRITE;
            if (PWRITE) wdata_d = PWDATA;
        end

        wait_inc = (&wait_q) ? wait_q : wait_q + 8'd1;
        wait_d   = wait_q;
        if (setup_entry)           wait_d = '0;
        else if (acc_smp && !PREADY) wait_d = wait_inc;

        err_hit    = '0;
        err_hit[0] = in_setup && !access_ph;
        err_hit[1] = acc_smp && ((PADDR != addr_q) || (PWRITE != write_q) ||
                                 (write_q && (PWDATA != wdata_q)));
        err_hit[2] = PENABLE && !PSELx;
        err_hit[3] = in_setup && write_q && mask_bit(RD_ONLY_MASK, addr_q);
        err_hit[4] = in_setup && !write_q && mask_bit(WR_ONLY_MASK, addr_q);
        err_hit[5] = acc_smp && !PREADY && !w6_fired_q && (wait_inc == MAX_WAIT_C);
        err_hit[6] = in_setup && !addr_in_map(addr_q);

        w6_fired_d = w6_fired_q;
        if (setup_entry)     w6_fired_d = 1'b0;
        else if (err_hit[5]) w6_fired_d = 1'b1;

        err_code_d = lowest_code(err_hit);
        err_addr_d = (err_code_d == 3'd3) ? PADDR : addr_q;
    end

    // Latched transfer attributes carry no reset; they are reloaded on every setup.
    always_ff @(posedge PCLK) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            err_addr_q   <= '0;
            err_status_q <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            err_cnt_q    <= '0;
            wait_max_q   <= '0;
        end else begin
            err_valid_q <= |err_hit;
            if (|err_hit) begin
                err_code_q <= err_code_d;
                err_addr_q <= err_addr_d;
            end
            // Clear wins over any statistic update sampled on the same edge.
            if (clr_i) begin
                err_status_q <= '0;
                wr_cnt_q     <= '0;
                rd_cnt_q     <= '0;
                err_cnt_q    <= '0;
                wait_max_q   <= '0;
            end else begin
                err_status_q <= err_status_q | err_hit;
                if (|err_hit) err_cnt_q <= sat_inc(err_cnt_q);
                if (done) begin
                    if (write_q) wr_cnt_q <= sat_inc(wr_cnt_q);
                    else         rd_cnt_q <= sat_inc(rd_cnt_q);
                    if (wait_q > wait_max_q) wait_max_q <= wait_q;
                end
            end
        end
    end

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_addr   = err_addr_q;
    assign err_status = err_status_q;
    assign wr_cnt     = wr_cnt_q;
    assign rd_cnt     = rd_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign wait_max   = wait_max_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed bench for apb_protocol_monitor; small counter width exposes saturation.
module tb_apb_protocol_monitor;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn, PSELx, PENABLE, PWRITE, PREADY, clr_i;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          err_valid;
    logic [2:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [6:0]    err_status;
    logic [CW-1:0] wr_cnt, rd_cnt, err_cnt;
    logic [7:0]    wait_max;

    int tests = 0;
    int fails = 0;
    int pulse_total = 0;
    int base;

    apb_protocol_monitor #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(8),
        .WR_ONLY_MASK(8'b0101_0100), .RD_ONLY_MASK(8'b0010_1000),
        .MAX_WAIT(16), .CNT_WIDTH(CW)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .clr_i(clr_i), .err_valid(err_valid), .err_code(err_code),
        .err_addr(err_addr), .err_status(err_status), .wr_cnt(wr_cnt),
        .rd_cnt(rd_cnt), .err_cnt(err_cnt), .wait_max(wait_max)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (err_valid === 1'b1) pulse_total++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_bus();
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PREADY = 1'b0;
    endtask

    task automatic clear_stats();
        idle_bus();
        clr_i = 1'b1; tick();
        clr_i = 1'b0; tick();
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int nwait);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PREADY = 1'b0;
        tick();
        PENABLE = 1'b1;
        repeat (nwait) tick();
        PREADY = 1'b1;
        tick();
        idle_bus();
    endtask

    task automatic check_all_zero(input string tag);
        tests++; if (err_valid !== 1'b0) begin fails++; $display("FAIL %s_err_valid: got %0b want 0", tag, err_valid); end
        tests++; if (err_code !== 3'd0) begin fails++; $display("FAIL %s_err_code: got %0d want 0", tag, err_code); end
        tests++; if (err_addr !== 8'd0) begin fails++; $display("FAIL %s_err_addr: got %0d want 0", tag, err_addr); end
        tests++; if (err_status !== 7'd0) begin fails++; $display("FAIL %s_err_status: got %b want 0", tag, err_status); end
        tests++; if (wr_cnt !== 4'd0) begin fails++; $display("FAIL %s_wr_cnt: got %0d want 0", tag, wr_cnt); end
        tests++; if (rd_cnt !== 4'd0) begin fails++; $display("FAIL %s_rd_cnt: got %0d want 0", tag, rd_cnt); end
        tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL %s_err_cnt: got %0d want 0", tag, err_cnt); end
        tests++; if (wait_max !== 8'd0) begin fails++; $display("FAIL %s_wait_max: got %0d want 0", tag, wait_max); end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; clr_i = 1'b0; PADDR = '0; PWDATA = '0; PRDATA = '0;
        idle_bus();
        tick(); tick();
        check_all_zero("reset");
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_ok();
        clear_stats(); base = pulse_total;
        xfer(1'b1, 8'd2, 8'hA5, 0);
        tick();
        tests++; if (wr_cnt !== 4'd1) begin fails++; $display("FAIL wr_ok_wr_cnt: got %0d want 1", wr_cnt); end
        tests++; if (rd_cnt !== 4'd0) begin fails++; $display("FAIL wr_ok_rd_cnt: got %0d want 0", rd_cnt); end
        tests++; if (wait_max !== 8'd0) begin fails++; $display("FAIL wr_ok_wait_max: got %0d want 0", wait_max); end
        tests++; if (err_status !== 7'd0) begin fails++; $display("FAIL wr_ok_status: got %b want 0", err_status); end
        tests++; if (pulse_total - base != 0) begin fails++; $display("FAIL wr_ok_pulses: got %0d want 0", pulse_total - base); end
    endtask

    task automatic test_read_wo();
        clear_stats(); base = pulse_total;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd4; tick();
        PENABLE = 1'b1; PREADY = 1'b1; tick();
        tests++; if (err_valid !== 1'b1) begin fails++; $display("FAIL rd_wo_valid: got %0b want 1", err_valid); end
        tests++; if (err_code !== 3'd5) begin fails++; $display("FAIL rd_wo_code: got %0d want 5", err_code); end
        tests++; if (err_addr !== 8'd4) begin fails++; $display("FAIL rd_wo_addr: got %0d want 4", err_addr); end
        tests++; if (err_status !== 7'b0010000) begin fails++; $display("FAIL rd_wo_status: got %b want 0010000", err_status); end
        tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL rd_wo_err_cnt: got %0d want 1", err_cnt); end
        idle_bus(); tick();
        tests++; if (err_valid !== 1'b0) begin fails++; $display("FAIL rd_wo_pulse_width: got %0b want 0", err_valid); end
        tests++; if (pulse_total - base != 1) begin fails++; $display("FAIL rd_wo_pulses: got %0d want 1", pulse_total - base); end
    endtask

    task automatic test_setup_stall();
        clear_stats(); base = pulse_total;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd3; tick();
        tick();
        tests++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin fails++; $display("FAIL stall_code: got v=%0b c=%0d want v=1 c=1", err_valid, err_code); end
        tests++; if (err_addr !== 8'd3) begin fails++; $display("FAIL stall_addr: got %0d want 3", err_addr); end
        PENABLE = 1'b1; PREADY = 1'b1; tick();
        tests++; if (err_valid !== 1'b0) begin fails++; $display("FAIL stall_access_err: got %0b want 0", err_valid); end
        idle_bus(); tick();
        tests++; if (rd_cnt !== 4'd1) begin fails++; $display("FAIL stall_rd_cnt: got %0d want 1", rd_cnt); end
        tests++; if (err_status !== 7'b0000001) begin fails++; $display("FAIL stall_status: got %b want 0000001", err_status); end
        tests++; if (pulse_total - base != 1) begin fails++; $display("FAIL stall_pulses: got %0d want 1", pulse_total - base); end
    endtask

    task automatic test_wait_timeout();
        clear_stats(); base = pulse_total;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd0; tick();
        PENABLE = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            tests++; if (err_valid !== (i == 16)) begin fails++; $display("FAIL timeout_valid_w%0d: got %0b want %0b", i, err_valid, (i == 16)); end
            if (i == 16) begin
                tests++; if (err_code !== 3'd6) begin fails++; $display("FAIL timeout_code: got %0d want 6", err_code); end
            end
        end
        PREADY = 1'b1; tick();
        idle_bus(); tick();
        tests++; if (wait_max !== 8'd20) begin fails++; $display("FAIL timeout_wait_max: got %0d want 20", wait_max); end
        tests++; if (rd_cnt !== 4'd1) begin fails++; $display("FAIL timeout_rd_cnt: got %0d want 1", rd_cnt); end
        tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL timeout_err_cnt: got %0d want 1", err_cnt); end
        tests++; if (err_status !== 7'b0100000) begin fails++; $display("FAIL timeout_status: got %b want 0100000", err_status); end
        tests++; if (pulse_total - base != 1) begin fails++; $display("FAIL timeout_pulses: got %0d want 1", pulse_total - base); end
    endtask

    task automatic test_addr_change();
        clear_stats(); base = pulse_total;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd9; PWDATA = 8'h11; tick();
        PENABLE = 1'b1; PREADY = 1'b1; PADDR = 8'd10; tick();
        tests++; if (err_valid !== 1'b1 || err_code !== 3'd2) begin fails++; $display("FAIL chg_code: got v=%0b c=%0d want v=1 c=2", err_valid, err_code); end
        tests++; if (err_addr !== 8'd9) begin fails++; $display("FAIL chg_addr: got %0d want 9", err_addr); end
        tests++; if (err_status !== 7'b1000010) begin fails++; $display("FAIL chg_status: got %b want 1000010", err_status); end
        tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL chg_err_cnt: got %0d want 1", err_cnt); end
        idle_bus(); tick();
        tests++; if (pulse_total - base != 1) begin fails++; $display("FAIL chg_pulses: got %0d want 1", pulse_total - base); end
    endtask

    task automatic test_penable_no_sel();
        clear_stats();
        PSELx = 1'b0; PENABLE = 1'b1; PADDR = 8'h33; tick();
        tests++; if (err_valid !== 1'b1 || err_code !== 3'd3) begin fails++; $display("FAIL nosel_code: got v=%0b c=%0d want v=1 c=3", err_valid, err_code); end
        tests++; if (err_addr !== 8'h33) begin fails++; $display("FAIL nosel_addr: got %0h want 33", err_addr); end
        idle_bus(); tick();
        tests++; if (err_status !== 7'b0000100) begin fails++; $display("FAIL nosel_status: got %b want 0000100", err_status); end
    endtask

    task automatic test_back_to_back();
        clear_stats(); base = pulse_total;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd0; PWDATA = 8'h01; tick();
        PENABLE = 1'b1; PREADY = 1'b1; tick();
        PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd1; PREADY = 1'b0; tick();
        PENABLE = 1'b1; PREADY = 1'b1; tick();
        idle_bus(); tick();
        tests++; if (wr_cnt !== 4'd1 || rd_cnt !== 4'd1) begin fails++; $display("FAIL b2b_cnts: got wr=%0d rd=%0d want 1/1", wr_cnt, rd_cnt); end
        tests++; if (pulse_total - base != 0) begin fails++; $display("FAIL b2b_pulses: got %0d want 0", pulse_total - base); end
    endtask

    task automatic test_saturation();
        clear_stats();
        for (int i = 0; i < 17; i++) xfer(1'b1, 8'd0, 8'(i), 0);
        tick();
        tests++; if (wr_cnt !== 4'hF) begin fails++; $display("FAIL sat_wr_cnt: got %0d want 15", wr_cnt); end
        tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL sat_err_cnt: got %0d want 0", err_cnt); end
        xfer(1'b0, 8'd0, 8'd0, 260);
        tick();
        tests++; if (wait_max !== 8'd255) begin fails++; $display("FAIL sat_wait_max: got %0d want 255", wait_max); end
    endtask

    task automatic test_reset_and_clear();
        clear_stats();
        xfer(1'b0, 8'd4, 8'd0, 0);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd0; PWDATA = 8'h5A; tick();
        PENABLE = 1'b1; tick(); tick();
        PRESETn = 1'b0; tick();
        base = pulse_total;
        check_all_zero("midreset");
        PRESETn = 1'b1; PREADY = 1'b1; tick();
        idle_bus(); tick(); tick();
        tests++; if (pulse_total - base != 0) begin fails++; $display("FAIL midreset_pulses: got %0d want 0", pulse_total - base); end
        tests++; if (wr_cnt !== 4'd0) begin fails++; $display("FAIL midreset_wr_cnt: got %0d want 0", wr_cnt); end
        for (int i = 0; i < 3; i++) begin
            PSELx = 1'b0; PENABLE = 1'b1; PADDR = 8'd7; tick();
            idle_bus(); tick();
        end
        tests++; if (err_cnt !== 4'd3) begin fails++; $display("FAIL clr_pre_err_cnt: got %0d want 3", err_cnt); end
        PSELx = 1'b0; PENABLE = 1'b1; clr_i = 1'b1; tick();
        tests++; if (err_valid !== 1'b1) begin fails++; $display("FAIL clr_same_valid: got %0b want 1", err_valid); end
        tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
        tests++; if (err_status !== 7'd0) begin fails++; $display("FAIL clr_status: got %b want 0", err_status); end
        clr_i = 1'b0; idle_bus(); tick();
        tests++; if (err_valid !== 1'b0 || err_cnt !== 4'd0) begin fails++; $display("FAIL clr_after: got v=%0b cnt=%0d want 0/0", err_valid, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_ok();
        test_read_wo();
        test_setup_stall();
        test_wait_timeout();
        test_addr_change();
        test_penable_no_sel();
        test_back_to_back();
        test_saturation();
        test_reset_and_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
